// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and types for the 1024x768 @ 60 Hz path.
// Renderers reuse X_W/Y_W for their pixel_x/pixel_y ports.
package vga_timing_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int VGA_H_VISIBLE = 1024;
  localparam int VGA_H_FRONT   = 24;
  localparam int VGA_H_SYNC    = 136;
  localparam int VGA_H_BACK    = 160;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT
                               + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 768;
  localparam int VGA_V_FRONT   = 3;
  localparam int VGA_V_SYNC    = 6;
  localparam int VGA_V_BACK    = 29;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT
                               + VGA_V_SYNC + VGA_V_BACK;

  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } sync_bits_t;

  // Map an "in sync region" flag onto the connector polarity.
  function automatic logic sync_level(input logic active,
                                      input logic neg);
    return active ^ neg;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// ce-gated shift register used to re-align sync/blank with render latency.
// Depth 0 collapses to a plain wire.
module sync_delay_line #(
  parameter int              W       = 3,
  parameter int              DEPTH   = 0,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst_n, ce};
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [DEPTH];

    // Shift one stage per enabled pixel; reset loads the idle pattern.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else if (ce) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running raster counters with registered sync/blank/strobe decodes.
// Decodes use next-state counts so they line up with pixel_x/pixel_y.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter bit SYNC_NEG   = 1'b1,
  parameter int SYNC_DELAY = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           video_on,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start,
  output logic [7:0]     frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_size
    $error("vga_timing: raster does not fit counter widths");
  end
  if (H_VISIBLE < 1 || H_SYNC < 1 || V_VISIBLE < 1 || V_SYNC < 1)
  begin : g_bad_region
    $error("vga_timing: visible and sync regions must be non-empty");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
    $error("vga_timing: SYNC_DELAY must be 0..7");
  end

  // Inclusive end-of-range values keep every compare inside the width.
  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_VLAST  = X_W'(H_VISIBLE - 1);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_VISIBLE + H_FRONT);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_VISIBLE + H_FRONT
                                             + H_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_VLAST  = Y_W'(V_VISIBLE - 1);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_VISIBLE + V_FRONT);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_VISIBLE + V_FRONT
                                             + V_SYNC - 1);

  localparam sync_bits_t SYNC_IDLE = '{
    video_on: 1'b0,
    hsync:    SYNC_NEG,
    vsync:    SYNC_NEG
  };

  logic [X_W-1:0] h_cnt, h_nxt;
  logic [Y_W-1:0] v_cnt, v_nxt;
  logic           h_wrap;
  sync_bits_t     dec_nxt, dec_q, dly;
  logic           line_nxt, frame_nxt;

  // Next-state counters: h wraps at H_LAST, v steps only on h wrap.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = v_cnt;
    if (h_wrap) v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
  end

  // Decode the position the counters are about to enter.
  always_comb begin
    dec_nxt.video_on = (h_nxt <= H_VLAST) && (v_nxt <= V_VLAST);
    dec_nxt.hsync    = sync_level((h_nxt >= HS_FIRST) &&
                                  (h_nxt <= HS_LAST), SYNC_NEG);
    dec_nxt.vsync    = sync_level((v_nxt >= VS_FIRST) &&
                                  (v_nxt <= VS_LAST), SYNC_NEG);
    line_nxt         = (h_nxt == '0);
    frame_nxt        = line_nxt && (v_nxt == '0);
  end

  // Reset parks on the last pixel so the first ce lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
    end else if (ce) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Registered decodes, strobes and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q       <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (ce) begin
      dec_q       <= dec_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
      if (frame_nxt) frame_count <= frame_count + 8'd1;
    end
  end

  sync_delay_line #(
    .W       (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (dec_q),
    .q     (dly)
  );

  assign pixel_x  = h_cnt;
  assign pixel_y  = v_cnt;
  assign video_on = dly.video_on;
  assign hsync    = dly.hsync;
  assign vsync    = dly.vsync;

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 1024×768 @ 60 Hz display path. It sits directly upstream of the character/score renderers: free-running horizontal and vertical counters drive the `pixel_x`/`pixel_y` coordinates those stages consume. It produces `hsync`, `vsync` and `video_on` to the DAC/connector, plus frame and line strobes for score-update logic. An optional delay line re-aligns sync and blank with the downstream render latency.

## Interface
- `H_VISIBLE`, 1024: active pixels per line
- `H_FRONT`, 24: horizontal front porch, pixels
- `H_SYNC`, 136: hsync width, pixels
- `H_BACK`, 160: horizontal back porch; H_TOTAL = 1344
- `V_VISIBLE`, 768: active lines
- `V_FRONT`, 3: vertical front porch, lines
- `V_SYNC`, 6: vsync width, lines
- `V_BACK`, 29: vertical back porch; V_TOTAL = 806
- `SYNC_NEG`, 1: 1 means hsync and vsync are active-low
- `SYNC_DELAY`, 0: extra cycles applied to `hsync`/`vsync`/`video_on` (0–7)
- `clk` in 1: pixel-domain clock, 65 MHz nominal
- `rst_n` in 1: asynchronous, active-low reset
- `ce` in 1: pixel enable; the block advances only on `clk` edges with `ce` = 1
- `pixel_x` out 11: current column, 0..H_TOTAL-1
- `pixel_y` out 10: current line, 0..V_TOTAL-1
- `video_on` out 1: `pixel_x` < H_VISIBLE and `pixel_y` < V_VISIBLE
- `hsync` out 1: horizontal sync, polarity set by `SYNC_NEG`
- `vsync` out 1: vertical sync, polarity set by `SYNC_NEG`
- `line_start` out 1: one-ce pulse while `pixel_x` = 0
- `frame_start` out 1: one-ce pulse while `pixel_x` = 0 and `pixel_y` = 0
- `frame_count` out 8: frames started since reset; wraps 255→0

## Operation
- **Horizontal counter:** when `ce` = 1, `h_cnt` increments. At H_TOTAL-1 it wraps to 0.
- **Vertical counter:** `v_cnt` increments only on the `h_cnt` wrap. At V_TOTAL-1, coincident with the `h_cnt` wrap, it wraps to 0.
- **Coordinates:** `pixel_x` = `h_cnt`, `pixel_y` = `v_cnt`, both driven straight from the registers.
- **Registered decodes:** `video_on`, `hsync`, `vsync`, `line_start` and `frame_start` are computed from the next-state counter values and registered. This keeps them exactly coincident with the `pixel_x`/`pixel_y` they describe.
- **hsync:** active for H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC, which is 1048..1183 at default.
- **vsync:** active for lines V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC, which is 771..776 at default. vsync does not depend on x.
- **frame_count:** increments on the same edge that raises `frame_start`.
- **Sync delay line:** when `SYNC_DELAY` > 0, `hsync`, `vsync` and `video_on` each pass through a shift register of that depth, clocked only when `ce` = 1. The coordinates, strobes and `frame_count` are never delayed.
- **ce = 0:** every register holds, including the delay line. Strobes hold their value and are not re-issued.
- **Reset, all values asynchronous:**
  - `h_cnt` = H_TOTAL-1 (1343), `v_cnt` = V_TOTAL-1 (805).
  - `video_on` = 0, `line_start` = 0, `frame_start` = 0, `frame_count` = 0.
  - `hsync`/`vsync` and every delay-line stage at their inactive level (1 when `SYNC_NEG` = 1).
  - Consequence: the first ce edge after release lands on (0,0) with `frame_start` = 1, so frame 0 is complete.
- **Reset mid-frame:** all outputs return to the reset values immediately, with no clock required. The counters resume from (1343,805).

## Timing
- **Latency:** 0 cycles from the counters to the decodes. Delayed outputs lag by exactly `SYNC_DELAY` ce-cycles.
- **Periods, with `ce` held high:**
  - Line period: 1344 cycles.
  - Frame period: 1344 × 806 = 1,083,264 cycles.
  - `line_start` high for 1 of every 1344 cycles.
  - `frame_start` high for 1 of every 1,083,264 cycles.
- **Widths:**
  - 11-bit `h_cnt` covers up to 2047; 10-bit `v_cnt` up to 1023.
  - Parameter sums exceeding those ranges are illegal; an elaboration-time check fails them.
- **Wrap handling:** comparisons use the exact end-of-range values, never overflow.

## Structure
- **Shared package `vga_timing_pkg`:**
  - Default 1024×768 timing localparams and the derived H_TOTAL/V_TOTAL.
  - Coordinate widths `X_W` = 11 and `Y_W` = 10, reused by the renderers for `pixel_x`/`pixel_y`.
- **Sub-module `sync_delay_line`:**
  - Parameterised width and depth, with `ce` and asynchronous reset-to-value.
  - Instantiated once over the 3-bit {`video_on`, `hsync`, `vsync`} bundle.
  - Depth 0 generates a wire-through.

## Test plan
- **Reset release, `ce`=1:** first edge gives `pixel_x`=0, `pixel_y`=0, `video_on`=1, `frame_start`=1, `line_start`=1, `frame_count`=1, `hsync`=`vsync`=1.
- **Line sweep:**
  - `video_on`=1 at x=1023 and 0 at x=1024.
  - `hsync`=0 exactly for x 1048..1183 (136 cycles).
  - x=1343→0 increments y and pulses `line_start`.
- **Full frame:**
  - `vsync`=0 for y 771..776 only.
  - y 805→0 at x wrap pulses `frame_start`; `frame_count` +1.
  - 256 frames wrap `frame_count` to 0.
  - Frame length measured as 1,083,264 cycles.
- **ce gating:** `ce` toggled 1/0 (one cycle each) yields a line length of 2688 clocks. `ce`=0 for 10 cycles at x=500 freezes all outputs unchanged.
- **`SYNC_DELAY`=3:** `hsync` falls 3 cycles after `pixel_x`=1048. `video_on` falls when `pixel_x`=1027. Coordinates are unaffected.
- **Async reset at (500,300):** all outputs take their reset values within the same cycle, without a clock edge. After release, the first ce edge gives (0,0) with `frame_start`=1.
